// File: rtl/matrix_loader.sv
// Serial-to-parallel loader for the 5x5 matrix inverse datapath: 25 row-major elements in, a11..a55 out.
// Optional below-diagonal detector is built only when MATRIX_LOADER_UPPER_TRI_CHECK_EN is defined.
//
// state | meaning
// LOAD  | accepting elements, in_ready = 1
// FULL  | complete matrix presented, mat_valid = 1, waiting for mat_ack
module matrix_loader #(
  parameter int DATA_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] a11, a12, a13, a14, a15,
  output logic [DATA_W-1:0] a21, a22, a23, a24, a25,
  output logic [DATA_W-1:0] a31, a32, a33, a34, a35,
  output logic [DATA_W-1:0] a41, a42, a43, a44, a45,
  output logic [DATA_W-1:0] a51, a52, a53, a54, a55,
  output logic              mat_valid,
  input  logic              mat_ack,
  output logic              err_len,
  output logic              not_upper_tri
);

  typedef enum logic {LOAD = 1'b0, FULL = 1'b1} state_t;

  state_t            state;
  logic [4:0]        idx;
  logic [DATA_W-1:0] mat [25];
  logic              xfer;

  assign in_ready = (state == LOAD) && !rst;
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      idx       <= '0;
      mat_valid <= 1'b0;
      err_len   <= 1'b0;
      for (int k = 0; k < 25; k++) mat[k] <= '0;
    end else if (state == LOAD) begin
      if (xfer) begin
        mat[idx] <= in_data;
        if (idx == 5'd24) begin
          state     <= FULL;
          mat_valid <= 1'b1;
          idx       <= '0;
          if (!in_last) err_len <= 1'b1;
        end else if (in_last) begin
          // short frame: drop it, partial entries stay but are never presented
          idx     <= '0;
          err_len <= 1'b1;
        end else begin
          idx <= idx + 5'd1;
        end
      end
    end else begin
      if (mat_ack) begin
        state     <= LOAD;
        mat_valid <= 1'b0;
        idx       <= '0;
      end
    end
  end

`ifdef MATRIX_LOADER_UPPER_TRI_CHECK_EN
  // bit k set when element k lies below the diagonal (row > column)
  localparam logic [31:0] BELOW_MASK = 32'h00F3_8C20;
  logic nut_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      nut_q <= 1'b0;
    end else if (xfer) begin
      nut_q <= ((idx == 5'd0) ? 1'b0 : nut_q) | (BELOW_MASK[idx] && (in_data != '0));
    end
  end

  assign not_upper_tri = nut_q;
`else
  assign not_upper_tri = 1'b0;
`endif

  assign a11 = mat[0];  assign a12 = mat[1];  assign a13 = mat[2];  assign a14 = mat[3];  assign a15 = mat[4];
  assign a21 = mat[5];  assign a22 = mat[6];  assign a23 = mat[7];  assign a24 = mat[8];  assign a25 = mat[9];
  assign a31 = mat[10]; assign a32 = mat[11]; assign a33 = mat[12]; assign a34 = mat[13]; assign a35 = mat[14];
  assign a41 = mat[15]; assign a42 = mat[16]; assign a43 = mat[17]; assign a44 = mat[18]; assign a45 = mat[19];
  assign a51 = mat[20]; assign a52 = mat[21]; assign a53 = mat[22]; assign a54 = mat[23]; assign a55 = mat[24];

endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader: directed frames plus randomized frames and valid gaps,
// checked against a frame-level model of what the presented matrix and flags must be.
module tb_matrix_loader;
  localparam int W = 20;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_last, mat_ack;
  logic [W-1:0]  in_data;
  logic          in_ready, mat_valid, err_len, not_upper_tri;
  logic [W-1:0]  a_out [25];

  int            checks = 0;
  int            failures = 0;
  logic [W-1:0]  frame [25];
  logic          exp_err;

  always #5 clk = ~clk;

  matrix_loader #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .a11(a_out[0]),  .a12(a_out[1]),  .a13(a_out[2]),  .a14(a_out[3]),  .a15(a_out[4]),
    .a21(a_out[5]),  .a22(a_out[6]),  .a23(a_out[7]),  .a24(a_out[8]),  .a25(a_out[9]),
    .a31(a_out[10]), .a32(a_out[11]), .a33(a_out[12]), .a34(a_out[13]), .a35(a_out[14]),
    .a41(a_out[15]), .a42(a_out[16]), .a43(a_out[17]), .a44(a_out[18]), .a45(a_out[19]),
    .a51(a_out[20]), .a52(a_out[21]), .a53(a_out[22]), .a54(a_out[23]), .a55(a_out[24]),
    .mat_valid(mat_valid), .mat_ack(mat_ack), .err_len(err_len), .not_upper_tri(not_upper_tri)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expected not_upper_tri for the current frame: any nonzero entry with row > column
  function automatic logic model_nut();
`ifdef MATRIX_LOADER_UPPER_TRI_CHECK_EN
    for (int k = 0; k < 25; k++)
      if ((k / 5) > (k % 5) && frame[k] != '0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic set_base();
    int base [25] = '{1, 8, -9, 7, 5,
                      0, 1, 0, 4, 4,
                      0, 0, 1, 2, 5,
                      0, 0, 0, 1, -5,
                      0, 0, 0, 0, 1};
    for (int k = 0; k < 25; k++) frame[k] = W'(base[k]);
  endtask

  task automatic set_random(input bit upper_only);
    for (int k = 0; k < 25; k++) begin
      frame[k] = W'($urandom);
      if (upper_only && (k / 5) > (k % 5)) frame[k] = '0;
    end
  endtask

  task automatic send_elem(input logic [W-1:0] d, input logic last, input bit gaps);
    int budget = 0;
    if (gaps) begin
      in_valid = 1'b0;
      while ($urandom_range(1, 0) == 0 && budget < 20) begin
        tick();
        budget++;
      end
    end
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    budget = 0;
    while (!in_ready && budget < 50) begin
      tick();
      budget++;
    end
    if (budget >= 50) check("ready_timeout", 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_matrix(input string tag);
    for (int k = 0; k < 25; k++)
      check($sformatf("%s_a%0d%0d", tag, k / 5 + 1, k % 5 + 1), a_out[k], frame[k]);
    check({tag, "_err_len"}, err_len, exp_err);
    check({tag, "_not_upper_tri"}, not_upper_tri, model_nut());
  endtask

  task automatic load_full(input string tag, input bit gaps, input bit ack_during);
    for (int k = 0; k < 25; k++) begin
      if (k == 24) begin
        mat_ack = 1'b0;
        check({tag, "_valid_before_last"}, mat_valid, 1'b0);
      end else begin
        mat_ack = ack_during;
      end
      send_elem(frame[k], k == 24, gaps);
    end
    check({tag, "_mat_valid"}, mat_valid, 1'b1);
    check({tag, "_in_ready_full"}, in_ready, 1'b0);
    check_matrix(tag);
  endtask

  task automatic ack_frame(input string tag);
    mat_ack = 1'b1;
    tick();
    mat_ack = 1'b0;
    check({tag, "_ack_valid"}, mat_valid, 1'b0);
    check({tag, "_ack_ready"}, in_ready, 1'b1);
    check({tag, "_ack_keep_a55"}, a_out[24], frame[24]);
  endtask

  initial begin
    bit same;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; mat_ack = 1'b0; in_data = '0;
    exp_err = 1'b0;
    tick();
    check("rst_in_ready", in_ready, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 25; k++) frame[k] = '0;
    check("rst_mat_valid", mat_valid, 1'b0);
    check("rst_in_ready_after", in_ready, 1'b1);
    check_matrix("rst");

    // scenario 1: back-to-back load of the reference matrix
    set_base();
    load_full("s1", 1'b0, 1'b0);
    check("s1_a13_const", a_out[2], 20'hFFFF7);
    check("s1_a45_const", a_out[19], 20'hFFFFB);
    check("s1_a11_const", a_out[0], 20'h00001);

    // scenario 2: hold for 10 cycles while upstream offers data
    same = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = W'($urandom);
      tick();
      for (int k = 0; k < 25; k++) if (a_out[k] !== frame[k]) same = 1'b0;
      if (in_ready !== 1'b0 || mat_valid !== 1'b1) same = 1'b0;
    end
    in_valid = 1'b0;
    check("s2_hold_stable", same, 1'b1);
    ack_frame("s2");

    // scenario 3: short frame, then a correct frame
    for (int k = 0; k < 10; k++) send_elem(W'($urandom), k == 9, 1'b0);
    exp_err = 1'b1;
    check("s3_short_err", err_len, 1'b1);
    tick();
    check("s3_short_no_valid", mat_valid, 1'b0);
    set_random(1'b0);
    load_full("s3", 1'b0, 1'b0);
    ack_frame("s3");

    // scenario 4: reset after 12 elements
    for (int k = 0; k < 12; k++) send_elem(W'($urandom), 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("s4_rst_in_ready", in_ready, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    exp_err = 1'b0;
    for (int k = 0; k < 25; k++) frame[k] = '0;
    check("s4_rst_valid", mat_valid, 1'b0);
    check_matrix("s4_rst");
    set_random(1'b1);
    load_full("s4", 1'b0, 1'b0);
    ack_frame("s4");

    // scenario 5: reference matrix with random gaps and ignored acks during LOAD
    set_base();
    load_full("s5", 1'b1, 1'b1);
    check("s5_a13_const", a_out[2], 20'hFFFF7);
    ack_frame("s5");

    // scenario 6: below-diagonal detection
    set_base();
    frame[21] = W'(3);
    load_full("s6a", 1'b0, 1'b0);
    ack_frame("s6a");
    set_base();
    load_full("s6b", 1'b0, 1'b0);
    ack_frame("s6b");

    // randomized frames, alternating general / upper-triangular content
    for (int f = 0; f < 6; f++) begin
      set_random(f % 2 == 1);
      load_full($sformatf("rnd%0d", f), 1'b1, 1'b0);
      ack_frame($sformatf("rnd%0d", f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
